// File: rtl/data_pipe_nto1_if.sv
// data_pipe_nto1_if: wide-in / narrow-out handshake bundle for the unpacker.
// The unpacker connects through the slave modport; the producer/consumer
// side (or a testbench) uses the master modport.
interface data_pipe_nto1_if #(
  parameter int DSIZE = 4,
  parameter int NSIZE = 2,
  parameter int CNT_W = $clog2(NSIZE + 1)
);
  logic [DSIZE*NSIZE-1:0] wr_data;
  logic                   wr_vld;
  logic                   wr_ready;
  logic [CNT_W-1:0]       wr_num;
  logic                   wr_last;
  logic [DSIZE-1:0]       rd_data;
  logic                   rd_vld;
  logic                   rd_ready;
  logic                   rd_last;

  modport master (
    output wr_data, wr_vld, wr_num, wr_last, rd_ready,
    input  wr_ready, rd_data, rd_vld, rd_last
  );

  modport slave (
    input  wr_data, wr_vld, wr_num, wr_last, rd_ready,
    output wr_ready, rd_data, rd_vld, rd_last
  );
endinterface

// File: rtl/data_pipe_nto1.sv
// data_pipe_nto1: width-down unpacker. Takes one wide word of NSIZE slices
// (DSIZE bits each) and emits the valid slices LSB first, one per narrow
// transfer, carrying packet framing through on rd_last.
//
// Build option: define DATA_PIPE_NTO1_PREFETCH_EN to add a second "next"
// wide register and a registered wr_ready (no rd_ready -> wr_ready path).
// Without it, a single holding register is used and wr_ready is
// combinational from rd_ready so back-to-back words still stream gap-free.
module data_pipe_nto1 #(
  parameter int DSIZE = 4,
  parameter int NSIZE = 2,
  parameter int CNT_W = $clog2(NSIZE + 1)
) (
  input  logic            clock,
  input  logic            rst,
  data_pipe_nto1_if.slave bus
);

  localparam logic [CNT_W-1:0] NSIZE_C = CNT_W'(NSIZE);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] LOAD  = 1'b1;

  // Current word being unpacked
  logic [0:0]             state;
  logic [DSIZE*NSIZE-1:0] hold_data;
  logic [CNT_W-1:0]       hold_num;
  logic                   hold_last;
  logic [CNT_W-1:0]       idx;

  logic [CNT_W-1:0] in_num;
  logic [DSIZE-1:0] cur_slice;
  logic             occupied;
  logic             last_slice;
  logic             rd_fire;
  logic             wr_fire;
  logic             wr_ready_int;

  assign occupied   = (state == LOAD);
  assign last_slice = occupied && (idx == (hold_num - CNT_W'(1)));
  assign rd_fire    = occupied && bus.rd_ready && !rst;
  assign wr_fire    = bus.wr_vld && wr_ready_int;

  // Normalise the incoming slice count: 0 and anything above NSIZE mean a full word
  always_comb begin
    in_num = bus.wr_num;
    if ((bus.wr_num == '0) || (bus.wr_num > NSIZE_C)) begin
      in_num = NSIZE_C;
    end
  end

  // Select the slice addressed by idx out of the holding register
  always_comb begin
    cur_slice = '0;
    for (int i = 0; i < NSIZE; i++) begin
      if (idx == CNT_W'(i)) begin
        cur_slice = hold_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks mid-reset
  assign bus.rd_vld   = occupied && !rst;
  assign bus.rd_data  = rst ? '0 : cur_slice;
  assign bus.rd_last  = occupied && !rst && hold_last && last_slice;
  assign bus.wr_ready = wr_ready_int;

`ifdef DATA_PIPE_NTO1_PREFETCH_EN

  // Second wide slot that parks a word while the current one drains
  logic [DSIZE*NSIZE-1:0] nxt_data;
  logic [CNT_W-1:0]       nxt_num;
  logic                   nxt_last;
  logic                   nxt_full;
  logic                   nxt_full_d;
  logic                   wr_ready_q;
  logic                   cur_free;

  // The current slot is free this cycle if empty or its last slice leaves now
  assign cur_free     = !occupied || (rd_fire && last_slice);
  assign wr_ready_int = wr_ready_q && !rst;

  // Next-slot occupancy after this edge; wr_ready is that value registered.
  // A write can only fire when the next slot is empty, so when the current
  // slot frees up either the parked word or the incoming one moves in.
  always_comb begin
    nxt_full_d = nxt_full;
    if (cur_free) begin
      nxt_full_d = 1'b0;
    end else if (wr_fire) begin
      nxt_full_d = 1'b1;
    end
  end

  // Current-slot FSM: refill from the next slot first, then from the input
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= EMPTY;
      idx       <= '0;
      hold_data <= '0;
      hold_num  <= '0;
      hold_last <= 1'b0;
    end else if (cur_free) begin
      idx <= '0;
      if (nxt_full) begin
        state     <= LOAD;
        hold_data <= nxt_data;
        hold_num  <= nxt_num;
        hold_last <= nxt_last;
      end else if (wr_fire) begin
        state     <= LOAD;
        hold_data <= bus.wr_data;
        hold_num  <= in_num;
        hold_last <= bus.wr_last;
      end else begin
        state <= EMPTY;
      end
    end else if (rd_fire) begin
      idx <= idx + CNT_W'(1);
    end
  end

  // Next slot captures an accepted word only while the current slot is busy
  always_ff @(posedge clock) begin
    if (rst) begin
      nxt_data   <= '0;
      nxt_num    <= '0;
      nxt_last   <= 1'b0;
      nxt_full   <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      nxt_full   <= nxt_full_d;
      wr_ready_q <= !nxt_full_d;
      if (!cur_free && wr_fire) begin
        nxt_data <= bus.wr_data;
        nxt_num  <= in_num;
        nxt_last <= bus.wr_last;
      end
    end
  end

`else

  // Accept when empty, or when the last slice leaves in this same cycle
  assign wr_ready_int = !rst && (!occupied || (rd_fire && last_slice));

  // Single-register FSM: EMPTY -> LOAD on accept, LOAD -> EMPTY or reload on last slice
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= EMPTY;
      idx       <= '0;
      hold_data <= '0;
      hold_num  <= '0;
      hold_last <= 1'b0;
    end else if (wr_fire) begin
      state     <= LOAD;
      idx       <= '0;
      hold_data <= bus.wr_data;
      hold_num  <= in_num;
      hold_last <= bus.wr_last;
    end else if (rd_fire) begin
      if (last_slice) begin
        state <= EMPTY;
        idx   <= '0;
      end else begin
        idx <= idx + CNT_W'(1);
      end
    end
  end

`endif

endmodule

// File: doc/data_pipe_nto1.md
# data_pipe_nto1

Width-down unpacker, the inverse of the 1-to-N packer. Accepts one wide word of NSIZE slices of DSIZE bits each over a valid/ready handshake and emits the slices one per cycle on a narrow valid/ready stream. Partial final words and packet framing are carried through. Sits on the read side of the wide FIFOs, feeding narrow consumers in the same clock domain.

## Interface
- DSIZE, 4, width of one narrow slice
- NSIZE, 2, slices per wide word (≥2)
- CNT_W, $clog2(NSIZE+1), width of wr_num
- clock  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_data  input  DSIZE*NSIZE  wide word; slice i = wr_data[i*DSIZE +: DSIZE]
- wr_vld  input  1  wide word valid
- wr_ready  output  1  unpacker can accept a wide word
- wr_num  input  CNT_W  valid slices in the word, 1..NSIZE; 0 means NSIZE, values >NSIZE clamp to NSIZE
- wr_last  input  1  word is the final word of a packet
- rd_data  output  DSIZE  current narrow slice
- rd_vld  output  1  rd_data valid
- rd_ready  input  1  consumer accepts the slice
- rd_last  output  1  final valid slice of a wr_last word

## Operation
- Wide transfer when wr_vld & wr_ready; narrow transfer when rd_vld & rd_ready.
- Holding register captures wr_data, the clamped wr_num and wr_last. Slice index idx starts at 0 on load.
- Slice order: LSB first, so slice 0, then 1, … up to num-1. Slices ≥ num are never emitted.
- rd_data = hold[idx*DSIZE +: DSIZE]; rd_vld = holding register occupied.
- On each narrow transfer, idx increments. If idx == num-1, the register empties (or reloads, see Configuration).
- rd_last = rd_vld & hold_last & (idx == num-1).
- rd_data and rd_last stay stable while rd_vld & !rd_ready. The stream never retracts rd_vld.
- State machine, baseline build:
  - EMPTY → LOAD on a wide transfer.
  - LOAD → EMPTY on the last narrow transfer with no wide transfer in the same cycle.
  - LOAD → LOAD, reloading, on the last narrow transfer with a simultaneous wide transfer.
- wr_num = 1 word: emits a single slice.

## Timing
- Reset: while rst is high, wr_ready=0, rd_vld=0, rd_last=0, rd_data=0, idx=0, and the buffer is empty. wr_ready rises the first cycle after rst falls.
- Latency: a word accepted at edge k gives slice 0 with rd_vld=1 in cycle k+1.
- Throughput: with continuous wr_vld and rd_ready=1, one slice per cycle and no bubbles between words. A word takes num cycles.
- Baseline wr_ready = EMPTY | (rd_vld & rd_ready & idx==num-1). This is a combinational path from rd_ready.
- rst asserted mid-word: remaining slices are dropped, and all state returns to reset values on the next edge.
- wr_vld with wr_ready=0: no effect. The producer holds its data.

## Configuration
- DATA_PIPE_NTO1_PREFETCH_EN defined:
  - Adds a second, "next" wide register.
  - wr_ready is registered and equals "next slot empty", so there is no combinational rd_ready → wr_ready path.
  - On the last slice, the current register loads from next if occupied, with zero bubble.
  - Up to two wide words are buffered.
  - Latency from wide accept to slice 0 is unchanged (1 cycle) when the buffer is empty.
- Not defined:
  - Single holding register with the combinational wr_ready described above.
  - Behaviour on rd_* is cycle-identical when rd_ready is held high.

## Test plan
- Normal stream:
  - Stimulus: DSIZE=4, NSIZE=2, 50 words 0x10,0x32,0x54,… with rd_ready=1.
  - Required: rd_data = 0,1,2,3,… for 100 cycles with no gaps.
  - Required: rd_last only on the final slice, when wr_last is set on word 50.
- Backpressure (read stalled):
  - Stimulus: rd_ready=0 for 20 cycles after the first word 0xA5.
  - Required: rd_data holds at 0x5 with rd_vld=1.
  - Required: wr_ready=0 (baseline), or 0 after the second word (prefetch).
  - Required: on release, the output is 0x5, then 0xA, then the next word.
- Partial word:
  - Stimulus: word 0xC3 with wr_num=1 and wr_last=1.
  - Required: a single slice 0x3 with rd_last=1, then rd_vld=0.
- Read empty:
  - Stimulus: rd_ready=1 with wr_vld=0 for 30 cycles.
  - Required: rd_vld stays 0 and wr_ready=1.
- Reset mid-word:
  - Stimulus: assert rst after slice 0 of 0x76.
  - Required: the next cycle has rd_vld=0 and wr_ready=0.
  - Required: after release, a new word 0x98 yields 0x8, then 0x9. Slice 0x7 never appears.
- Clamp:
  - Stimulus: wr_num=0 and wr_num=3 with NSIZE=2.
  - Required: both emit 2 slices.
